// File: rtl/pipeline_pkg.sv
// Shared width helpers for the pipeline credit collector and its result FIFO.
package pipeline_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Counters must hold the full depth, so they need one more value than the pointer index.
  function automatic int credit_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_BIT_WIDTH  = 10;
  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int CREDIT_W           = clog2(DEFAULT_FIFO_DEPTH + 1);
  localparam int PTR_W              = clog2(DEFAULT_FIFO_DEPTH) + 1;

endpackage

// File: rtl/pipeline_credit_collector_fifo.sv
// First-word-fall-through result buffer with wrap-bit pointers; the head is always
// the registered entry at the read pointer.
module sync_fifo_fwft
  import pipeline_pkg::*;
#(
  parameter int BIT_WIDTH  = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic [BIT_WIDTH-1:0]                push_data,
  input  logic                                pop,
  output logic [BIT_WIDTH-1:0]                head_data,
  output logic                                empty,
  output logic                                full,
  output logic [credit_width(FIFO_DEPTH)-1:0] count
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = credit_width(FIFO_DEPTH);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [BIT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                 do_write;
  logic                 do_read;
  logic [PW-1:0]        fill;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fill      = wr_ptr_q - rd_ptr_q;
  assign count     = CW'(fill);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign do_read  = pop && !empty;
  assign do_write = push && (!full || do_read);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PW'(do_write);
    rd_ptr_d = rd_ptr_q + PW'(do_read);
    if (do_write) mem_d[wr_ptr_q[AW-1:0]] = push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/pipeline_credit_collector.sv
// Receiving end of a fixed-latency delay line: credits gate upstream issue so every
// result in flight owns a buffer slot, and results drain on a valid/ready handshake.
module pipeline_credit_collector
  import pipeline_pkg::*;
#(
  parameter int BIT_WIDTH  = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                issue_valid,
  output logic                                issue_ready,
  input  logic                                pipe_valid,
  input  logic [BIT_WIDTH-1:0]                pipe_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BIT_WIDTH-1:0]                out_data,
  output logic [credit_width(FIFO_DEPTH)-1:0] credits,
  output logic                                err_unexpected
);

  localparam int CW = credit_width(FIFO_DEPTH);

  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic          err_q, err_d;
  logic          issue;
  logic          pop;
  logic          accepted;
  logic          overflow;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] occupancy;

  assign issue_ready    = (credits_q != '0);
  assign issue          = issue_valid && issue_ready;
  assign out_valid      = !fifo_empty;
  assign pop            = out_valid && out_ready;
  assign accepted       = pipe_valid && (in_flight_q != '0);
  assign overflow       = accepted && fifo_full && !pop;
  assign credits        = credits_q;
  assign err_unexpected = err_q;

  // A result with nothing in flight is stale (e.g. left over across a reset) and is dropped.
  always_comb begin
    credits_d   = credits_q - CW'(issue) + CW'(pop);
    in_flight_d = in_flight_q + CW'(issue) - CW'(accepted);
    err_d       = err_q || (pipe_valid && (in_flight_q == '0)) || overflow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q   <= CW'(FIFO_DEPTH);
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  sync_fifo_fwft #(
    .BIT_WIDTH (BIT_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accepted),
    .push_data(pipe_data),
    .pop      (pop),
    .head_data(out_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (occupancy)
  );

  // Every slot is exactly one of: free credit, result in flight, or buffered result.
  property p_credit_conservation;
    @(posedge clk) disable iff (reset)
      (32'(credits_q) + 32'(in_flight_q) + 32'(occupancy)) == FIFO_DEPTH;
  endproperty
  a_credit_conservation: assert property (p_credit_conservation);

endmodule

// File: tb/tb_pipeline_credit_collector.sv
// Self-checking bench: a 5-stage delay line feeds the collector, issue order is
// scoreboarded against pop order, and directed vectors cover credits and backpressure.
module tb_pipeline_credit_collector;

  logic       clk;
  logic       reset;
  logic       issue_valid;
  logic       issue_ready;
  logic       pipe_valid;
  logic [9:0] pipe_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [3:0] credits;
  logic       err_unexpected;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_pops  = 0;

  logic [4:0] dl_valid;
  logic [9:0] dl_data [5];
  logic       inj_valid;
  logic [9:0] inj_data;
  logic [9:0] tag;
  logic [9:0] exp_q [$];

  pipeline_credit_collector #(
    .BIT_WIDTH (10),
    .FIFO_DEPTH(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .pipe_valid    (pipe_valid),
    .pipe_data     (pipe_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .credits       (credits),
    .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream delay line: each issued item carries a sequence tag and emerges 5 cycles later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_valid <= '0;
      for (int i = 0; i < 5; i++) dl_data[i] <= '0;
      tag <= '0;
      exp_q.delete();
    end else begin
      dl_valid   <= {dl_valid[3:0], issue_valid && issue_ready};
      dl_data[0] <= tag;
      for (int i = 1; i < 5; i++) dl_data[i] <= dl_data[i-1];
      if (issue_valid && issue_ready) begin
        exp_q.push_back(tag);
        tag <= tag + 10'd1;
      end
    end
  end

  assign pipe_valid = dl_valid[4] | inj_valid;
  assign pipe_data  = inj_valid ? inj_data : dl_data[4];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  // Drive inputs at the current falling edge and advance one full cycle.
  task automatic applyStimulus(input logic iv, input logic ordy, input logic inj,
                               input logic [9:0] injd);
    issue_valid = iv;
    out_ready   = ordy;
    inj_valid   = inj;
    inj_data    = injd;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset       = 1'b1;
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    inj_valid   = 1'b0;
    inj_data    = '0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    sb_pops = 0;
  endtask

  // Every pop must deliver the oldest issued tag.
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) checkOutput("sb_pop_without_issue", 1, 0);
      else checkOutput("sb_out_data_order", out_data, exp_q.pop_front());
      sb_pops++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: actual running, required finished");
    $fatal(1, "[TB] simulation timeout");
  end

  typedef struct {
    int iv;
    int ordy;
    int exp_ir;
    int exp_cred;
    int exp_ov;
    int chk_data;
    int exp_data;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  int first_ov;
  int min_cred;

  initial begin
    // Backpressure: 8 issues fill the buffer with out_ready low, then a drain of 0..7.
    vecs[0]  = '{1, 0, 1, 8, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 7, 0, 0, 0};
    vecs[2]  = '{1, 0, 1, 6, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 5, 0, 0, 0};
    vecs[4]  = '{1, 0, 1, 4, 0, 0, 0};
    vecs[5]  = '{1, 0, 1, 3, 0, 0, 0};
    vecs[6]  = '{1, 0, 1, 2, 1, 1, 0};
    vecs[7]  = '{1, 0, 1, 1, 1, 1, 0};
    vecs[8]  = '{1, 0, 0, 0, 1, 1, 0};
    vecs[9]  = '{1, 0, 0, 0, 1, 1, 0};
    vecs[10] = '{1, 0, 0, 0, 1, 1, 0};
    vecs[11] = '{1, 0, 0, 0, 1, 1, 0};
    vecs[12] = '{1, 0, 0, 0, 1, 1, 0};
    vecs[13] = '{1, 0, 0, 0, 1, 1, 0};
    vecs[14] = '{0, 1, 0, 0, 1, 1, 0};
    vecs[15] = '{0, 1, 1, 1, 1, 1, 1};
    vecs[16] = '{0, 1, 1, 2, 1, 1, 2};
    vecs[17] = '{0, 1, 1, 3, 1, 1, 3};
    vecs[18] = '{0, 1, 1, 4, 1, 1, 4};
    vecs[19] = '{0, 1, 1, 5, 1, 1, 5};
    vecs[20] = '{0, 1, 1, 6, 1, 1, 6};
    vecs[21] = '{0, 1, 1, 7, 1, 1, 7};
    vecs[22] = '{0, 0, 1, 8, 0, 0, 0};

    reset       = 1'b1;
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    inj_valid   = 1'b0;
    inj_data    = '0;

    $display("[TB] reset then idle");
    doReset();
    for (int c = 0; c < 20; c++) begin
      checkOutput("idle_issue_ready", issue_ready, 1);
      checkOutput("idle_credits", credits, 8);
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_err", err_unexpected, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
    end

    $display("[TB] streaming 20 items through the 5-cycle delay line");
    doReset();
    first_ov = -1;
    min_cred = 99;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && first_ov < 0) first_ov = c;
      if (int'(credits) < min_cred) min_cred = int'(credits);
      applyStimulus(tag < 10'd20, 1'b1, 1'b0, '0);
    end
    checkOutput("stream_first_out_valid_cycle", first_ov, 6);
    checkOutput("stream_min_credits", min_cred, 2);
    checkOutput("stream_pop_count", sb_pops, 20);
    checkOutput("stream_err", err_unexpected, 0);
    checkOutput("stream_final_credits", credits, 8);

    $display("[TB] full backpressure vectors");
    doReset();
    for (int i = 0; i < NVEC; i++) begin
      checkOutput($sformatf("bp[%0d].issue_ready", i), issue_ready, vecs[i].exp_ir);
      checkOutput($sformatf("bp[%0d].credits", i), credits, vecs[i].exp_cred);
      checkOutput($sformatf("bp[%0d].out_valid", i), out_valid, vecs[i].exp_ov);
      if (vecs[i].chk_data != 0)
        checkOutput($sformatf("bp[%0d].out_data", i), out_data, vecs[i].exp_data);
      applyStimulus(vecs[i].iv != 0, vecs[i].ordy != 0, 1'b0, '0);
    end
    checkOutput("bp_pop_count", sb_pops, 8);
    checkOutput("bp_err", err_unexpected, 0);

    $display("[TB] issue and pop at the credit boundary, 24 items across pointer wrap");
    doReset();
    for (int c = 0; c < 14; c++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("wrap_full_credits", credits, 0);
    checkOutput("wrap_full_issue_ready", issue_ready, 0);
    checkOutput("wrap_full_out_valid", out_valid, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("wrap_freed_credit", credits, 1);
    checkOutput("wrap_freed_issue_ready", issue_ready, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("wrap_issue_and_pop_credits", credits, 1);
    for (int c = 16; c < 300 && sb_pops < 24; c++)
      applyStimulus(tag < 10'd24, (c % 3) != 0, 1'b0, '0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("wrap_pop_count", sb_pops, 24);
    checkOutput("wrap_final_credits", credits, 8);
    checkOutput("wrap_final_out_valid", out_valid, 0);
    checkOutput("wrap_err", err_unexpected, 0);

    $display("[TB] spurious result with nothing in flight");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h3FF);
    inj_valid = 1'b0;
    checkOutput("spurious_err", err_unexpected, 1);
    checkOutput("spurious_out_valid", out_valid, 0);
    checkOutput("spurious_credits", credits, 8);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("spurious_err_sticky", err_unexpected, 1);
    checkOutput("spurious_still_empty", out_valid, 0);
    checkOutput("spurious_credits_later", credits, 8);

    $display("[TB] reset mid-stream with 3 buffered and 4 in flight");
    doReset();
    for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_credits_before", credits, 1);
    checkOutput("mid_out_valid_before", out_valid, 1);
    checkOutput("mid_head_before", out_data, 0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_out_valid", out_valid, 0);
    checkOutput("mid_reset_credits", credits, 8);
    checkOutput("mid_reset_issue_ready", issue_ready, 1);
    @(negedge clk);
    reset   = 1'b0;
    sb_pops = 0;
    for (int c = 0; c < 10; c++) begin
      checkOutput("mid_after_out_valid", out_valid, 0);
      checkOutput("mid_after_credits", credits, 8);
      checkOutput("mid_after_err", err_unexpected, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    end
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("mid_restart_pop_count", sb_pops, 3);
    checkOutput("mid_restart_credits", credits, 8);
    checkOutput("mid_restart_err", err_unexpected, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
